qam64_symbol_mapper: RTL and testbench

Upstream stage of the 64-QAM modulator symbol path. Accepts a byte stream over a valid/ready handshake and regroups it MSB-first into 6-bit symbols. Gray-maps each symbol to a pair of signed 4-bit I/Q amplitude levels and presents them, one symbol per pacing tick, to the symbol storage stage. Pacing uses the `I_data`/`Q_data`/`IQ_empty` strobe convention.

---
 rtl/qam64_symbol_mapper.sv | 110 +++++++++++
 tb/tb_qam64_symbol_mapper.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam64_symbol_mapper.sv
// 64-QAM symbol mapper: regroups a byte stream MSB-first into 6-bit symbols,
// Gray-maps each to signed 4-bit I/Q levels and emits one per pacing tick.
module qam64_symbol_mapper #(
  parameter int unsigned SYM_DIV = 1
) (
  input  logic       sym_clk,
  input  logic       rst_sym,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       flush,
  output logic [3:0] I_data,
  output logic [3:0] Q_data,
  output logic       IQ_empty,
  output logic       underrun
);

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
  // byte_ready depends only on registered state and rst_sym, never on byte_valid.

  localparam logic [7:0] DIV_LAST = 8'(SYM_DIV - 1);

  logic [15:0] bit_buf_q, bit_buf_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        flush_pend_q, flush_pend_d;
  logic        active_q, active_d;
  logic [3:0]  i_data_q, i_data_d;
  logic [3:0]  q_data_q, q_data_d;
  logic        iq_empty_q, iq_empty_d;
  logic        underrun_q, underrun_d;

  logic        tick;
  logic        accept;
  logic        emit_full;
  logic        emit_pad;
  logic        emit;
  logic [15:0] shifted;
  logic [4:0]  cnt_after;

  // Gray -> binary index, then level 2*idx-7 == {idx,1} - 8 (flip the MSB).
  function automatic logic [3:0] gray_level(input logic [2:0] g);
    logic [2:0] idx;
    idx[2] = g[2];
    idx[1] = g[2] ^ g[1];
    idx[0] = idx[1] ^ g[0];
    return {idx, 1'b1} ^ 4'b1000;
  endfunction

  always_comb begin
    tick       = (div_cnt_q == 8'd0);
    byte_ready = !rst_sym && !flush_pend_q && (bit_cnt_q <= 5'd8);
    accept     = byte_valid && byte_ready;
    emit_full  = tick && (bit_cnt_q >= 5'd6);
    emit_pad   = tick && flush_pend_q && (bit_cnt_q != 5'd0) && (bit_cnt_q < 5'd6);
    emit       = emit_full || emit_pad;

    // Bits below bit_cnt are always zero, so a padded symbol needs no masking.
    shifted   = emit ? (bit_buf_q << 6) : bit_buf_q;
    cnt_after = emit_pad ? 5'd0 : (emit_full ? (bit_cnt_q - 5'd6) : bit_cnt_q);

    bit_buf_d = shifted | (accept ? ({byte_in, 8'h00} >> cnt_after) : 16'h0000);
    bit_cnt_d = cnt_after + (accept ? 5'd8 : 5'd0);

    if (flush_pend_q) begin
      flush_pend_d = !((bit_cnt_q == 5'd0) || emit_pad);
    end else begin
      flush_pend_d = flush;
    end

    active_d   = (flush_pend_q && !flush_pend_d) ? 1'b0 : (active_q || accept);
    underrun_d = tick && active_q && (bit_cnt_q < 5'd6) && !flush_pend_q;

    iq_empty_d = !emit;
    i_data_d   = emit ? gray_level(bit_buf_q[15:13]) : i_data_q;
    q_data_d   = emit ? gray_level(bit_buf_q[12:10]) : q_data_q;

    div_cnt_d  = (div_cnt_q == DIV_LAST) ? 8'd0 : (div_cnt_q + 8'd1);
  end

  always_ff @(posedge sym_clk) begin
    if (rst_sym) begin
      bit_buf_q    <= 16'h0000;
      bit_cnt_q    <= 5'd0;
      div_cnt_q    <= 8'd0;
      flush_pend_q <= 1'b0;
      active_q     <= 1'b0;
      i_data_q     <= 4'd0;
      q_data_q     <= 4'd0;
      iq_empty_q   <= 1'b1;
      underrun_q   <= 1'b0;
    end else begin
      bit_buf_q    <= bit_buf_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      flush_pend_q <= flush_pend_d;
      active_q     <= active_d;
      i_data_q     <= i_data_d;
      q_data_q     <= q_data_d;
      iq_empty_q   <= iq_empty_d;
      underrun_q   <= underrun_d;
    end
  end

  assign I_data   = i_data_q;
  assign Q_data   = q_data_q;
  assign IQ_empty = iq_empty_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_qam64_symbol_mapper.sv
// Self-checking bench for qam64_symbol_mapper: a bit-stream model fills expected
// symbol queues as bytes are accepted; monitors pop and compare on each strobe.
module tb_qam64_symbol_mapper;

  // ---------------- clock / reset ----------------
  logic sym_clk = 1'b0;
  logic rst_sym = 1'b1;
  always #5 sym_clk = ~sym_clk;

  // SYM_DIV = 1 instance
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       flush = 1'b0;
  logic [3:0] I_data, Q_data;
  logic       IQ_empty, underrun;

  // SYM_DIV = 4 instance
  logic [7:0] byte_in4 = 8'h00;
  logic       byte_valid4 = 1'b0;
  logic       byte_ready4;
  logic       flush4 = 1'b0;
  logic [3:0] I_data4, Q_data4;
  logic       IQ_empty4, underrun4;

  qam64_symbol_mapper #(.SYM_DIV(1)) dut (
    .sym_clk(sym_clk), .rst_sym(rst_sym), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .flush(flush), .I_data(I_data), .Q_data(Q_data),
    .IQ_empty(IQ_empty), .underrun(underrun)
  );

  qam64_symbol_mapper #(.SYM_DIV(4)) dut4 (
    .sym_clk(sym_clk), .rst_sym(rst_sym), .byte_in(byte_in4), .byte_valid(byte_valid4),
    .byte_ready(byte_ready4), .flush(flush4), .I_data(I_data4), .Q_data(Q_data4),
    .IQ_empty(IQ_empty4), .underrun(underrun4)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];
  logic       bitq1[$];
  logic       bitq4[$];
  int push4 = 0;
  int strobes1 = 0;
  int strobes4 = 0;
  int ur_cnt1 = 0;
  int ready_low4 = 0;
  int cyc = 0;
  int prev4 = -1;
  logic pace_on = 1'b0;
  logic rst_d;
  logic [7:0] hold1, hold4, e1, e4;

  always @(posedge sym_clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst_sym;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: table Gray decode, integer level arithmetic.
  function automatic logic [3:0] lvl(input logic [2:0] g);
    int idx;
    case (g)
      3'b000: idx = 0;
      3'b001: idx = 1;
      3'b011: idx = 2;
      3'b010: idx = 3;
      3'b110: idx = 4;
      3'b111: idx = 5;
      3'b101: idx = 6;
      default: idx = 7;
    endcase
    return 4'(2 * idx - 7);
  endfunction

  function automatic logic [7:0] map_sym(input logic [5:0] s);
    return {lvl(s[5:3]), lvl(s[2:0])};
  endfunction

  task automatic model_step(input int id, input logic acc, input logic [7:0] b, input logic f);
    logic q[$];
    logic [5:0] s;
    if (id == 0) q = bitq1; else q = bitq4;
    if (acc) for (int i = 7; i >= 0; i--) q.push_back(b[i]);
    while (q.size() >= 6) begin
      for (int j = 0; j < 6; j++) s = {s[4:0], q.pop_front()};
      if (id == 0) exp_q.push_back(map_sym(s));
      else begin exp4_q.push_back(map_sym(s)); push4++; end
    end
    if (f && q.size() > 0) begin
      s = 6'd0;
      for (int j = 0; j < 6; j++) begin
        if (q.size() > 0) s = {s[4:0], q.pop_front()};
        else s = {s[4:0], 1'b0};
      end
      if (id == 0) exp_q.push_back(map_sym(s));
      else begin exp4_q.push_back(map_sym(s)); push4++; end
    end
    if (id == 0) bitq1 = q; else bitq4 = q;
  endtask

  // ---------------- monitors ----------------
  always @(negedge sym_clk) begin
    if (rst_d === 1'b1) begin
      chk("rst_iq_empty", 32'(IQ_empty), 32'd1);
      chk("rst_iq_zero", 32'({I_data, Q_data}), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      hold1 = 8'h00;
    end else if (rst_d === 1'b0) begin
      if (underrun === 1'b1) ur_cnt1++;
      if (IQ_empty === 1'b0) begin
        strobes1++;
        chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e1 = exp_q.pop_front();
          chk("symbol_iq", 32'({I_data, Q_data}), 32'(e1));
        end
        hold1 = {I_data, Q_data};
      end else begin
        chk("hold_iq", 32'({I_data, Q_data}), 32'(hold1));
      end
    end
  end

  always @(negedge sym_clk) begin
    if (rst_d === 1'b1) begin
      hold4 = 8'h00;
    end else if (rst_d === 1'b0) begin
      if (IQ_empty4 === 1'b0) begin
        strobes4++;
        chk("strobe4_expected", 32'(exp4_q.size() > 0), 32'd1);
        if (exp4_q.size() > 0) begin
          e4 = exp4_q.pop_front();
          chk("symbol4_iq", 32'({I_data4, Q_data4}), 32'(e4));
        end
        if (pace_on) begin
          if (prev4 >= 0) chk("pace_interval", 32'(cyc - prev4), 32'd4);
          prev4 = cyc;
        end
        hold4 = {I_data4, Q_data4};
      end else begin
        chk("hold4_iq", 32'({I_data4, Q_data4}), 32'(hold4));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b, input logic f);
    int w;
    logic done;
    w = 0;
    done = 1'b0;
    while (!done && w < 32) begin
      @(negedge sym_clk);
      byte_valid = 1'b1; byte_in = b; flush = 1'b0;
      #1;
      if (byte_ready) begin
        flush = f;
        @(posedge sym_clk);
        model_step(0, 1'b1, b, f);
        done = 1'b1;
      end else begin
        w++;
      end
    end
    chk("accept_in_time", 32'(done), 32'd1);
  endtask

  task automatic send4(input logic [7:0] b, input logic f);
    int w;
    logic done;
    w = 0;
    done = 1'b0;
    while (!done && w < 32) begin
      @(negedge sym_clk);
      byte_valid4 = 1'b1; byte_in4 = b; flush4 = 1'b0;
      #1;
      if (byte_ready4) begin
        flush4 = f;
        @(posedge sym_clk);
        model_step(1, 1'b1, b, f);
        done = 1'b1;
      end else begin
        ready_low4++;
        w++;
      end
    end
    chk("accept4_in_time", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sym_clk);
      byte_valid = 1'b0; flush = 1'b0;
      byte_valid4 = 1'b0; flush4 = 1'b0;
    end
  endtask

  task automatic do_flush();
    @(negedge sym_clk);
    byte_valid = 1'b0; flush = 1'b1;
    @(posedge sym_clk);
    model_step(0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge sym_clk);
    rst_sym = 1'b1; byte_valid = 1'b0; flush = 1'b0;
    @(posedge sym_clk);
    exp_q.delete(); exp4_q.delete(); bitq1.delete(); bitq4.delete();
    @(negedge sym_clk);
    rst_sym = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int s0, u0;

  initial begin
    // Reset held 3 cycles with valid bytes offered.
    byte_valid = 1'b1; byte_in = 8'hA5; byte_valid4 = 1'b1; byte_in4 = 8'h5A;
    repeat (3) begin
      @(negedge sym_clk);
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      chk("rst_byte_ready4", 32'(byte_ready4), 32'd0);
    end
    @(negedge sym_clk);
    rst_sym = 1'b0; byte_valid = 1'b0; byte_valid4 = 1'b0;
    // Nothing was consumed: no strobe, no underrun.
    s0 = strobes1;
    repeat (5) begin
      @(negedge sym_clk);
      chk("post_rst_no_underrun", 32'(underrun), 32'd0);
    end
    chk("post_rst_no_strobe", 32'(strobes1 - s0), 32'd0);

    // Zero stream. The third byte stalls one cycle, leaving a 4-bit tick.
    s0 = strobes1; u0 = ur_cnt1;
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b1);
    idle(8);
    chk("zero_strobes", 32'(strobes1 - s0), 32'd4);
    chk("zero_underruns", 32'(ur_cnt1 - u0), 32'd1);
    chk("zero_last_iq", 32'({I_data, Q_data}), 32'h99);

    // Gray mapping; 0xFF with flush leaves 11 padded to 110000 -> I=+1, Q=-7.
    s0 = strobes1; u0 = ur_cnt1;
    send(8'h24, 1'b0); send(8'h92, 1'b0); send(8'h49, 1'b0); send(8'hFF, 1'b1);
    idle(8);
    chk("gray_strobes", 32'(strobes1 - s0), 32'd6);
    chk("gray_underruns", 32'(ur_cnt1 - u0), 32'd1);
    chk("gray_pad_iq", 32'({I_data, Q_data}), 32'h19);
    chk("gray_ready_after", 32'(byte_ready), 32'd1);

    // Underrun: one byte, then pulses every tick until flush.
    send(8'hA5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge sym_clk);
      byte_valid = 1'b0; flush = 1'b0;
      chk("underrun_seq", 32'(underrun), 32'(i >= 2));
    end
    do_flush();
    for (int i = 0; i < 6; i++) begin
      @(negedge sym_clk);
      flush = 1'b0;
      chk("underrun_after_flush", 32'(underrun), 32'(i == 0));
    end
    chk("underrun_pad_iq", 32'({I_data, Q_data}), 32'hF9);

    // Mid-stream reset discards buffered bits.
    send(8'hC3, 1'b0); send(8'h3C, 1'b0);
    do_reset();
    s0 = strobes1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sym_clk);
      chk("midrst_iq_empty", 32'(IQ_empty), 32'd1);
      chk("midrst_underrun", 32'(underrun), 32'd0);
    end
    chk("midrst_no_strobe", 32'(strobes1 - s0), 32'd0);
    s0 = strobes1;
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b1);
    idle(8);
    chk("midrst_zero_strobes", 32'(strobes1 - s0), 32'd4);

    // Pacing with SYM_DIV = 4 and continuous random bytes.
    prev4 = -1;
    pace_on = 1'b1;
    for (int i = 0; i < 31; i++) send4(8'($urandom_range(0, 255)), 1'(i == 30));
    for (int i = 0; i < 100 && exp4_q.size() > 0; i++) idle(1);
    idle(10);
    pace_on = 1'b0;
    chk("pace_strobes", 32'(strobes4), 32'(push4));
    chk("pace_symbols", 32'(push4), 32'd42);
    chk("pace_ready_drops", 32'(ready_low4 > 0), 32'd1);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("exp4_q_drained", 32'(exp4_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
